// File: rtl/global_package.sv
// Shared data types for the options parser datapath.
package global_package;

    typedef logic [14:0][31:0] a_unsigned_32_15;

    typedef struct packed {
        logic [15:0] mss;
        logic [3:0]  wscale;
        logic        sackPermitted;
        logic        tsPresent;
        logic [31:0] tsVal;
        logic [31:0] tsEcr;
        logic [3:0]  optCount;
    } st_ParsedOptions;

endpackage

// File: rtl/options_parser_arb_pkg.sv
// Types and defaults for the OptionsParser arbiter.
package options_parser_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } e_ArbStates;

    function automatic int unsigned idWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/options_parser_arbiter_rr_arbiter.sv
// Round-robin winner selection: search starts just above lastGrant and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     lastGrant,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    logic           aboveHit;
    logic           anyHit;
    logic [IDW-1:0] aboveIdx;
    logic [IDW-1:0] anyIdx;

    // Wrap-around is the lowest request overall when nothing sits above lastGrant.
    always_comb begin
        aboveHit = 1'b0;
        anyHit   = 1'b0;
        aboveIdx = '0;
        anyIdx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !aboveHit && (i > 32'(lastGrant))) begin
                aboveHit = 1'b1;
                aboveIdx = IDW'(i);
            end
            if (req[i] && !anyHit) begin
                anyHit = 1'b1;
                anyIdx = IDW'(i);
            end
        end
        valid  = anyHit;
        winner = aboveHit ? aboveIdx : anyIdx;
    end

endmodule

// File: rtl/options_parser_arbiter.sv
// Shares one OptionsParser among NUM_REQ requesters, one transaction at a time,
// with a sticky response watchdog.
module options_parser_arbiter
    import global_package::*, options_parser_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    localparam int unsigned IDW    = idWidth(NUM_REQ),
    localparam int unsigned WDW    = $clog2(TIMEOUT + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  a_unsigned_32_15 [NUM_REQ-1:0]    req_fields_sig,
    input  logic [NUM_REQ-1:0]               req_fields_sync,
    output logic [NUM_REQ-1:0]               req_fields_notify,
    output st_ParsedOptions                  resp_parsed_sig,
    output logic [NUM_REQ-1:0]               resp_parsed_notify,
    input  logic [NUM_REQ-1:0]               resp_parsed_sync,
    output a_unsigned_32_15                  par_fields_sig,
    output logic                             par_fields_sync,
    input  logic                             par_fields_notify,
    input  st_ParsedOptions                  par_parsed_sig,
    output logic                             par_parsed_sync,
    input  logic                             par_parsed_notify,
    output logic [IDW-1:0]                   grant_id,
    output logic                             busy,
    output logic                             err_timeout
);

    e_ArbStates      state;
    logic [IDW-1:0]  grantId;
    logic [IDW-1:0]  lastGrant;
    a_unsigned_32_15 fieldsLatch;
    st_ParsedOptions parsedLatch;
    logic [WDW-1:0]  wdCount;
    logic            errTimeout;

    logic [IDW-1:0]  winner;
    logic            reqValid;
    logic            grantNow;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) uArb (
        .req       (req_fields_sync),
        .lastGrant (lastGrant),
        .winner    (winner),
        .valid     (reqValid)
    );

    // Grant pulse is combinational, so it is held off while reset is asserted.
    assign grantNow = (state == IDLE) && reqValid && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grantId     <= '0;
            lastGrant   <= IDW'(NUM_REQ - 1);
            fieldsLatch <= '0;
            parsedLatch <= '0;
            wdCount     <= '0;
            errTimeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantNow) begin
                        grantId     <= winner;
                        fieldsLatch <= req_fields_sig[winner];
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (par_fields_notify) begin
                        wdCount <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (wdCount != WDW'(TIMEOUT)) begin
                        wdCount <= wdCount + 1'b1;
                    end
                    if (wdCount == WDW'(TIMEOUT - 1)) begin
                        errTimeout <= 1'b1;
                    end
                    if (par_parsed_notify) begin
                        parsedLatch <= par_parsed_sig;
                        state       <= RETURN;
                    end
                end
                RETURN: begin
                    if (resp_parsed_sync[grantId]) begin
                        lastGrant <= grantId;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_fields_notify  = '0;
        resp_parsed_notify = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_fields_notify[i]  = grantNow && (winner == IDW'(i));
            resp_parsed_notify[i] = (state == RETURN) && (grantId == IDW'(i));
        end
    end

    assign par_fields_sig  = fieldsLatch;
    assign par_fields_sync = (state == SEND);
    assign par_parsed_sync = (state == WAIT);
    assign resp_parsed_sig = parsedLatch;
    assign grant_id        = grantId;
    assign busy            = (state != IDLE);
    assign err_timeout     = errTimeout;

endmodule

// File: tb/tb_options_parser_arbiter.sv
// Directed table-driven bench for options_parser_arbiter with a scripted parser.
module tb_options_parser_arbiter;
    import global_package::*;

    localparam int unsigned TMO = 256;

    logic                      clk = 1'b0;
    logic                      rst;
    a_unsigned_32_15 [3:0]     req_fields_sig;
    logic [3:0]                req_fields_sync;
    logic [3:0]                req_fields_notify;
    st_ParsedOptions           resp_parsed_sig;
    logic [3:0]                resp_parsed_notify;
    logic [3:0]                resp_parsed_sync;
    a_unsigned_32_15           par_fields_sig;
    logic                      par_fields_sync;
    logic                      par_fields_notify;
    st_ParsedOptions           par_parsed_sig;
    logic                      par_parsed_sync;
    logic                      par_parsed_notify;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      err_timeout;

    options_parser_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_fields_sig     (req_fields_sig),
        .req_fields_sync    (req_fields_sync),
        .req_fields_notify  (req_fields_notify),
        .resp_parsed_sig    (resp_parsed_sig),
        .resp_parsed_notify (resp_parsed_notify),
        .resp_parsed_sync   (resp_parsed_sync),
        .par_fields_sig     (par_fields_sig),
        .par_fields_sync    (par_fields_sync),
        .par_fields_notify  (par_fields_notify),
        .par_parsed_sig     (par_parsed_sig),
        .par_parsed_sync    (par_parsed_sync),
        .par_parsed_notify  (par_parsed_notify),
        .grant_id           (grant_id),
        .busy               (busy),
        .err_timeout        (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  reqs;
        int unsigned acceptDelay;
        int unsigned replyDelay;
        int unsigned holdCycles;
        logic [1:0]  expGrant;
    } vec_t;

    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;
    logic errModel = 1'b0;
    logic badNotify;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] g);
        logic [3:0] one;
        one = 4'b0001;
        return one << g;
    endfunction

    function automatic a_unsigned_32_15 mkFields(input int i, input int k);
        a_unsigned_32_15 f;
        for (int j = 0; j < 15; j++) begin
            f[j] = {8'(8'hA0 + i), 8'(k), 16'(j)};
        end
        return f;
    endfunction

    function automatic st_ParsedOptions mkParsed(input int k);
        st_ParsedOptions p;
        p.mss           = 16'(1400 + k);
        p.wscale        = 4'(k);
        p.sackPermitted = 1'(k & 1);
        p.tsPresent     = 1'b1;
        p.tsVal         = 32'(32'hDEAD0000 + k);
        p.tsEcr         = 32'(k * 7);
        p.optCount      = 4'd3;
        return p;
    endfunction

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_busy"}, 128'(busy), 0);
        chk({tag, "_grantId"}, 128'(grant_id), 0);
        chk({tag, "_errTimeout"}, 128'(err_timeout), 0);
        chk({tag, "_reqNotify"}, 128'(req_fields_notify), 0);
        chk({tag, "_respNotify"}, 128'(resp_parsed_notify), 0);
        chk({tag, "_parFieldsSync"}, 128'(par_fields_sync), 0);
        chk({tag, "_parParsedSync"}, 128'(par_parsed_sync), 0);
        chk({tag, "_respSig"}, 128'(resp_parsed_sig), 0);
        chk({tag, "_parFieldsSig"}, 128'(par_fields_sig == '0), 1);
    endtask

    task automatic doTxn(input int k);
        vec_t v;
        int   n;
        v = vecs[k];
        @(negedge clk);
        for (int i = 0; i < 4; i++) req_fields_sig[i] = mkFields(i, k);
        req_fields_sync = v.reqs;
        #1;
        n = 0;
        while (req_fields_notify == 4'b0000 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_fields_notify == 4'b0000) begin
            chk($sformatf("grantTimeout_v%0d", k), 128'(req_fields_notify), 128'(oh(v.expGrant)));
            return;
        end
        chk($sformatf("grantPulse_v%0d", k), 128'(req_fields_notify), 128'(oh(v.expGrant)));
        badNotify = 1'b0;

        for (int unsigned c = 0; c <= v.acceptDelay; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("sendSync_v%0d_c%0d", k, c), 128'(par_fields_sync), 1);
            chk($sformatf("sendFields_v%0d", k), 128'(par_fields_sig == mkFields(int'(v.expGrant), k)), 1);
            chk($sformatf("sendGrantId_v%0d", k), 128'(grant_id), 128'(v.expGrant));
            chk($sformatf("sendBusy_v%0d", k), 128'(busy), 1);
            badNotify = badNotify | (req_fields_notify != 4'b0000) | (resp_parsed_notify != 4'b0000);
            if (c == 0 && v.acceptDelay > 0) begin
                par_parsed_sig    = ~mkParsed(k);
                par_parsed_notify = 1'b1;
            end else begin
                par_parsed_notify = 1'b0;
            end
            par_fields_notify = (c == v.acceptDelay);
        end

        for (int unsigned c = 0; c <= v.replyDelay; c++) begin
            @(negedge clk);
            #1;
            par_fields_notify = (c == 0 && v.replyDelay > 0);
            par_parsed_notify = 1'b0;
            if (c >= TMO) errModel = 1'b1;
            chk($sformatf("waitFieldsSync_v%0d", k), 128'(par_fields_sync), 0);
            chk($sformatf("waitParsedSync_v%0d_c%0d", k, c), 128'(par_parsed_sync), 1);
            chk($sformatf("waitErr_v%0d_c%0d", k, c), 128'(err_timeout), 128'(errModel));
            badNotify = badNotify | (req_fields_notify != 4'b0000) | (resp_parsed_notify != 4'b0000);
            if (c == v.replyDelay) begin
                par_parsed_sig    = mkParsed(k);
                par_parsed_notify = 1'b1;
            end
        end

        @(negedge clk);
        par_parsed_notify = 1'b0;
        par_fields_notify = 1'b0;
        par_parsed_sig    = ~mkParsed(k);
        for (int unsigned h = 0; h <= v.holdCycles; h++) begin
            if (h > 0) @(negedge clk);
            #1;
            chk($sformatf("retNotify_v%0d_h%0d", k, h), 128'(resp_parsed_notify), 128'(oh(v.expGrant)));
            chk($sformatf("retSig_v%0d", k), 128'(resp_parsed_sig), 128'(mkParsed(k)));
            chk($sformatf("retParsedSync_v%0d", k), 128'(par_parsed_sync), 0);
            chk($sformatf("retErr_v%0d", k), 128'(err_timeout), 128'(errModel));
            badNotify = badNotify | (req_fields_notify != 4'b0000);
            resp_parsed_sync = (h == v.holdCycles) ? oh(v.expGrant) : (~oh(v.expGrant));
        end

        @(negedge clk);
        resp_parsed_sync = 4'b0000;
        req_fields_sync  = 4'b0000;
        #1;
        chk($sformatf("idleAfter_v%0d", k), 128'(busy), 0);
        chk($sformatf("noNotifyWhileBusy_v%0d", k), 128'(badNotify), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL globalTimeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = '{4'b1111, 0,   0,  0, 2'd0};
        vecs[1]  = '{4'b1111, 1,   2,  0, 2'd1};
        vecs[2]  = '{4'b1111, 0,   1,  0, 2'd2};
        vecs[3]  = '{4'b1111, 2,   0,  0, 2'd3};
        vecs[4]  = '{4'b1111, 0,   0,  0, 2'd0};
        vecs[5]  = '{4'b0100, 3,   5,  0, 2'd2};
        vecs[6]  = '{4'b0011, 0,   0,  0, 2'd0};
        vecs[7]  = '{4'b1010, 1,   1, 10, 2'd1};
        vecs[8]  = '{4'b1001, 0,   0,  0, 2'd3};
        vecs[9]  = '{4'b0001, 0, 260,  0, 2'd0};
        vecs[10] = '{4'b0110, 0,   0,  0, 2'd1};
        vecs[11] = '{4'b1100, 0,   0,  0, 2'd2};
        vecs[12] = '{4'b1111, 0,   0,  0, 2'd0};

        rst               = 1'b0;
        req_fields_sig    = '0;
        req_fields_sync   = '0;
        resp_parsed_sync  = '0;
        par_fields_notify = 1'b0;
        par_parsed_sig    = '0;
        par_parsed_notify = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idleNoReqNotify", 128'(req_fields_notify), 0);
            chk("idleNoReqBusy", 128'(busy), 0);
        end

        for (int k = 0; k < 12; k++) doTxn(k);

        // Reset while the parser is being waited on; err_timeout is still set here.
        @(negedge clk);
        for (int i = 0; i < 4; i++) req_fields_sig[i] = mkFields(i, 20);
        req_fields_sync = 4'b0100;
        #1;
        chk("midGrant", 128'(req_fields_notify), 128'(4'b0100));
        @(negedge clk);
        #1;
        par_fields_notify = 1'b1;
        @(negedge clk);
        #1;
        par_fields_notify = 1'b0;
        chk("midWaitSync", 128'(par_parsed_sync), 1);
        chk("midErrBefore", 128'(err_timeout), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetOutputs("midRstNow");
        @(negedge clk);
        #1;
        checkResetOutputs("midRstNext");
        rst             = 1'b1;
        req_fields_sync = 4'b0000;
        errModel        = 1'b0;

        doTxn(12);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("finalIdleNotify", 128'(req_fields_notify), 0);
            chk("finalIdleBusy", 128'(busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
